mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit. It consumes the operands that the ALU operand muxes

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_sign_fix.sv | 48 ++++
 rtl/mult_div_unit.sv | 143 ++++++++++++++
 tb/tb_mult_div_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states
// and the default operand width.
package mdu_pkg;
    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;
endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational result fix-up: sign correction of magnitude results and the
// divide-by-zero override, producing the final HI/LO values.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH-1:0] raw,
    input  logic               sign_a,
    input  logic               sign_b,
    input  mdu_op_e            op,
    input  logic               div_zero,
    input  logic [WIDTH-1:0]   a_raw,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic [2*WIDTH-1:0] neg_prod;
    logic [WIDTH-1:0]   raw_hi;
    logic [WIDTH-1:0]   raw_lo;

    assign neg_prod = -raw;
    assign raw_hi   = raw[2*WIDTH-1:WIDTH];
    assign raw_lo   = raw[WIDTH-1:0];

    always_comb begin
        hi = raw_hi;
        lo = raw_lo;
        case (op)
            OP_MULT: begin
                if (sign_a ^ sign_b) begin
                    hi = neg_prod[2*WIDTH-1:WIDTH];
                    lo = neg_prod[WIDTH-1:0];
                end
            end
            OP_DIV, OP_DIVU: begin
                if (div_zero) begin
                    hi = a_raw;
                    lo = '1;
                end else if (op == OP_DIV) begin
                    // Overflow case (-2^(W-1) / -1) wraps to 0x80.. naturally here.
                    lo = (sign_a ^ sign_b) ? -raw_lo : raw_lo;
                    hi = sign_a ? -raw_hi : raw_hi;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// One shift-add or restoring shift-subtract step per cycle, then a fix-up cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] ALU_A,
    input  logic [WIDTH-1:0] ALU_B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    mdu_op_e            op_q, op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               in_signed, in_sa, in_sb;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign in_signed = ~Op[0];
    assign in_sa     = in_signed & ALU_A[WIDTH-1];
    assign in_sb     = in_signed & ALU_B[WIDTH-1];

    // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_shift - {1'b0, b_q};

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .raw      (acc_q),
        .sign_a   (sign_a_q),
        .sign_b   (sign_b_q),
        .op       (op_q),
        .div_zero (b_q == '0),
        .a_raw    (a_raw_q),
        .hi       (fix_hi),
        .lo       (fix_lo)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        b_d      = b_q;
        a_raw_d  = a_raw_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = (state_q == ST_FIX);
        case (state_q)
            ST_IDLE: begin
                if (HiWrite) hi_d = WriteData;
                if (LoWrite) lo_d = WriteData;
                if (Start) begin
                    op_d     = mdu_op_e'(Op);
                    sign_a_d = in_sa;
                    sign_b_d = in_sb;
                    a_raw_d  = ALU_A;
                    acc_d    = {{WIDTH{1'b0}}, (in_sa ? -ALU_A : ALU_A)};
                    b_d      = in_sb ? -ALU_B : ALU_B;
                    count_d  = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (op_q[1]) begin
                    if (!div_trial[WIDTH])
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            a_raw_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            op_q     <= OP_MULT;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            a_raw_q  <= a_raw_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, results, corner cases,
// start-while-busy, MTHI/MTLO and mid-operation reset.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [1:0]   Op = 2'b00;
    logic [W-1:0] ALU_A = '0;
    logic [W-1:0] ALU_B = '0;
    logic         HiWrite = 1'b0;
    logic         LoWrite = 1'b0;
    logic [W-1:0] WriteData = '0;
    logic         Busy, Done;
    logic [W-1:0] HI, LO;

    int checks = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch at the next rising edge, then scramble the operand inputs.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        Start = 1'b1; Op = op; ALU_A = a; ALU_B = b;
        @(posedge Clk);
        #1;
        Start = 1'b0; Op = 2'($urandom); ALU_A = $urandom; ALU_B = $urandom;
    endtask

    // Count negedges until Done (bounded) and Busy-high negedges on the way.
    task automatic wait_done(output int n, output int bc);
        n = 0; bc = 0;
        while (!Done && n < 100) begin
            @(negedge Clk);
            n++;
            if (Busy) bc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        int n, bc;
        launch(op, a, b);
        wait_done(n, bc);
        chk({tag, "_lat"}, 64'(n), 64'(W + 2));
        chk({tag, "_busy"}, 64'(bc), 64'(W + 1));
        chk({tag, "_hi"}, 64'(HI), 64'(eh));
        chk({tag, "_lo"}, 64'(LO), 64'(el));
        @(negedge Clk);
        chk({tag, "_pulse"}, 64'(Done), 64'd0);
    endtask

    initial begin
        int n, bc, dcnt;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);

        run_op("multu_7x6", 2'b01, 32'd7, 32'd6, 32'h0, 32'h2A);
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1);
        run_op("mult_n3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("div_n7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7dn2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
        run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_d0", 2'b11, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF);
        run_op("div_n5d0", 2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        // MTHI/MTLO while idle
        @(negedge Clk);
        HiWrite = 1'b1; WriteData = 32'hDEADBEEF;
        @(negedge Clk);
        HiWrite = 1'b0; LoWrite = 1'b1; WriteData = 32'h12345678;
        @(negedge Clk);
        LoWrite = 1'b0;
        chk("mthi", 64'(HI), 64'hDEADBEEF);
        chk("mtlo", 64'(LO), 64'h12345678);

        // Start with LoWrite at the same edge: write lands, result overwrites later
        @(negedge Clk);
        Start = 1'b1; Op = 2'b01; ALU_A = 32'd4; ALU_B = 32'd5;
        LoWrite = 1'b1; WriteData = 32'hCAFE0001;
        @(posedge Clk);
        #1;
        Start = 1'b0; LoWrite = 1'b0; ALU_A = $urandom; ALU_B = $urandom;
        chk("st_wr_lo", 64'(LO), 64'hCAFE0001);
        wait_done(n, bc);
        chk("st_wr_res_hi", 64'(HI), 64'h0);
        chk("st_wr_res_lo", 64'(LO), 64'd20);

        // Start/LoWrite while busy are ignored
        @(negedge Clk);
        launch(2'b01, 32'd3, 32'd3);
        repeat (4) @(negedge Clk);
        Start = 1'b1; Op = 2'b11; ALU_A = 32'd9; ALU_B = 32'd3;
        LoWrite = 1'b1; WriteData = 32'h55;
        @(negedge Clk);
        Start = 1'b0; LoWrite = 1'b0;
        chk("busy_lo_held", 64'(LO), 64'd20);
        wait_done(n, bc);
        chk("busy_ign_done", 64'(Done), 64'd1);
        chk("busy_ign_hi", 64'(HI), 64'h0);
        chk("busy_ign_lo", 64'(LO), 64'd9);
        repeat (2) @(negedge Clk);
        chk("busy_ign_idle", 64'(Busy), 64'd0);

        // Reset mid-operation
        launch(2'b01, 32'h1234, 32'h5678);
        repeat (10) @(negedge Clk);
        chk("mid_busy_pre", 64'(Busy), 64'd1);
        Reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(Busy), 64'd0);
        chk("mid_rst_hi", 64'(HI), 64'd0);
        chk("mid_rst_lo", 64'(LO), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done) dcnt++;
        end
        chk("mid_rst_nodone", 64'(dcnt), 64'd0);
        run_op("post_rst", 2'b01, 32'h10000, 32'h10000, 32'h1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
